// File: rtl/spm_param_top_if.sv
// Handshake and product readout bundle for the serial multiplier.
// SPM_ABORT_EN adds the abort request line.
interface spm_param_if #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 32,
  parameter int SEL_W = 1
);
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic             signed_mode;
  logic             start;
`ifdef SPM_ABORT_EN
  logic             abort;
`endif
  logic [SEL_W-1:0] prod_sel;
  logic [OUT_W-1:0] prod;
  logic             busy;
  logic             done;

  modport master (
    output mc, mp, signed_mode, start,
`ifdef SPM_ABORT_EN
    output abort,
`endif
    output prod_sel,
    input  prod, busy, done
  );

  modport slave (
    input  mc, mp, signed_mode, start,
`ifdef SPM_ABORT_EN
    input  abort,
`endif
    input  prod_sel,
    output prod, busy, done
  );
endinterface

// File: rtl/spm_param_top.sv
// Parametrised shift-add serial multiplier, one multiplier bit per clock.
// Optional macro SPM_ABORT_EN adds an abort input for in-flight operations.
module spm_param_top #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 32,
  parameter int SEL_W = 1
) (
  input  logic      clk,
  input  logic      rst,
  spm_param_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int NS = PW / OUT_W;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    product;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic load;
  logic step;
  logic fix;
  logic abort_req;

  logic             mc_s;
  logic             mp_s;
  logic [WIDTH-1:0] mc_abs;
  logic [WIDTH-1:0] mp_abs;

`ifdef SPM_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Magnitudes; -2^(WIDTH-1) negates to itself, which is its correct
  // unsigned magnitude.
  assign mc_s   = bus.signed_mode & bus.mc[WIDTH-1];
  assign mp_s   = bus.signed_mode & bus.mp[WIDTH-1];
  assign mc_abs = mc_s ? -bus.mc : bus.mc;
  assign mp_abs = mp_s ? -bus.mp : bus.mp;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes; start is only seen in IDLE/DONE.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort_req) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == LAST) begin
            state_nxt = FIX;
          end
        end
      end
      FIX: begin
        if (abort_req) begin
          state_nxt = IDLE;
        end else begin
          fix       = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add datapath; product only moves in FIX so prod is stable
  // while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      if (load) begin
        mcand  <= {{WIDTH{1'b0}}, mc_abs};
        mplier <= mp_abs;
        acc    <= '0;
        cnt    <= '0;
        neg    <= mc_s ^ mp_s;
      end
      if (step) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      if (fix) begin
        product <= neg ? -acc : acc;
      end
    end
  end

  assign bus.busy = (state == RUN) || (state == FIX);
  assign bus.done = (state == DONE);

  logic [(2**SEL_W)-1:0][OUT_W-1:0] slice;

  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_slice
    if (i < NS) begin : g_in
      assign slice[i] = product[i*OUT_W +: OUT_W];
    end else begin : g_out
      assign slice[i] = '0;
    end
  end

  assign bus.prod = slice[bus.prod_sel];
endmodule

// File: tb/tb_spm_param_top.sv
// Directed table-driven bench for spm_param_top at default parameters.
// Build with SPM_ABORT_EN to also exercise abort.
module tb_spm_param_top;
  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  logic [63:0] prev;
  logic [63:0] p;
  int          n;

  spm_param_if #(.WIDTH(32), .OUT_W(32), .SEL_W(1)) bus ();

  spm_param_top #(.WIDTH(32), .OUT_W(32), .SEL_W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mc;
    logic [31:0] mp;
    logic        mode;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_prod(output logic [63:0] r);
    bus.prod_sel = 1'b0;
    #1;
    r[31:0] = bus.prod;
    bus.prod_sel = 1'b1;
    #1;
    r[63:32] = bus.prod;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a,
                        input logic [31:0] b, input logic m,
                        input logic [63:0] exp);
    logic [63:0] r;
    int          c;
    bus.mc = a;
    bus.mp = b;
    bus.signed_mode = m;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, "_busy"}, 64'(bus.busy), 64'd1);
    read_prod(r);
    check({name, "_hold"}, r, prev);
    wait_done(c);
    check({name, "_cycles"}, 64'(c), 64'd33);
    check({name, "_done"}, 64'(bus.done), 64'd1);
    read_prod(r);
    check({name, "_prod"}, r, exp);
    prev = exp;
  endtask

  initial begin
    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
    vecs[1]  = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFF_FFFFFFF1};
    vecs[2]  = '{32'hFFFFFFFD, 32'h00000005, 1'b0, 64'h00000004_FFFFFFF1};
    vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
    vecs[4]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000};
    vecs[5]  = '{32'hFFFFFFF9, 32'h00000006, 1'b1, 64'hFFFFFFFF_FFFFFFD6};
    vecs[6]  = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000000};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001};
    vecs[8]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC0000000_80000000};
    vecs[9]  = '{32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000};
    vecs[10] = '{32'h00000007, 32'h00000006, 1'b0, 64'h00000000_0000002A};

    rst = 1'b1;
    bus.mc = '0;
    bus.mp = '0;
    bus.signed_mode = 1'b0;
    bus.start = 1'b0;
    bus.prod_sel = 1'b0;
`ifdef SPM_ABORT_EN
    bus.abort = 1'b0;
`endif
    prev = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_prod(p);
    check("rst_prod", p, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].mc, vecs[i].mp,
             vecs[i].mode, vecs[i].exp);
    end

    // start held through a whole operation, then re-accepted in DONE
    bus.mc = 32'd7;
    bus.mp = 32'd6;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    wait_done(n);
    check("held_cycles", 64'(n), 64'd33);
    check("held_done", 64'(bus.done), 64'd1);
    read_prod(p);
    check("held_prod", p, 64'd42);
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_done", 64'(bus.done), 64'd0);
    check("restart_busy", 64'(bus.busy), 64'd1);
    wait_done(n);
    read_prod(p);
    check("restart_prod", p, 64'd42);

    // operands change mid-RUN
    bus.mc = 32'd7;
    bus.mp = 32'd6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.mc = 32'hFFFFFFFF;
    bus.mp = 32'hFFFFFFFF;
    bus.signed_mode = 1'b1;
    wait_done(n);
    check("opchg_cycles", 64'(n), 64'd28);
    read_prod(p);
    check("opchg_prod", p, 64'd42);

    // reset during RUN
    bus.mc = 32'd9;
    bus.mp = 32'd9;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    read_prod(p);
    check("midrst_prod", p, 64'd0);
    prev = '0;

    // reset and start together: reset wins
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rststart_busy", 64'(bus.busy), 64'd0);
    check("rststart_done", 64'(bus.done), 64'd0);

`ifdef SPM_ABORT_EN
    run_op("abort_pre", 32'd2, 32'd3, 1'b0, 64'd6);
    bus.mc = 32'd9;
    bus.mp = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    read_prod(p);
    check("abort_prod", p, 64'd6);
    run_op("abort_post", 32'd9, 32'd9, 1'b0, 64'd81);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
